// File: rtl/pc_sequencer_if.sv
// Control and status bundle between the instruction sequencer and its
// surrounding fetch/decode logic.
interface pc_sequencer_if;
  logic        stall;
  logic        branch_taken;
  logic        is_jal;
  logic        is_jalr;
  logic [11:0] imm12;
  logic [19:0] imm20;
  logic [31:0] rs1_val;
  logic [31:0] inst_add;
  logic [31:0] link_add;
  logic        valid;
  logic        halted;
  logic        err;

  // Side that issues control requests and observes the instruction index
  modport master (
    output stall, branch_taken, is_jal, is_jalr, imm12, imm20, rs1_val,
    input  inst_add, link_add, valid, halted, err
  );

  // The sequencer itself
  modport slave (
    input  stall, branch_taken, is_jal, is_jalr, imm12, imm20, rs1_val,
    output inst_add, link_add, valid, halted, err
  );
endinterface

// File: rtl/pc_sequencer.sv
// Instruction-index sequencer: steps through 0..LAST_ADDR, takes
// JALR/JAL/branch redirects with a one-cycle flush bubble, and stops in
// HALT at the end of the program or on an out-of-range redirect.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   INIT  | one cycle after reset for the immediate table to load
//   RUN   | inst_add is live; control inputs honoured when not stalled
//   FLUSH | bubble after a redirect; control inputs ignored
//   HALT  | stopped (end of program or bad target); only reset exits
module pc_sequencer #(
  parameter int LAST_ADDR = 26,
  parameter int STEP      = 1
) (
  input logic            clk,
  input logic            reset,
  pc_sequencer_if.slave  bus
);

  localparam logic [31:0] LAST_W = 32'(LAST_ADDR);
  localparam logic [31:0] STEP_W = 32'(STEP);

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t      state_q, state_nxt;
  logic [31:0] inst_q, inst_nxt;
  logic [31:0] link_q, link_nxt;
  logic        err_q, err_nxt;

  logic [31:0] imm12_ext;
  logic [31:0] imm20_ext;
  logic [31:0] target;
  logic        redirect;

  assign imm12_ext = {{20{bus.imm12[11]}}, bus.imm12};
  assign imm20_ext = {{12{bus.imm20[19]}}, bus.imm20};
  assign redirect  = bus.is_jalr | bus.is_jal | bus.branch_taken;

  // Redirect target, highest-priority source wins; JALR keeps bit 0
  always_comb begin
    target = bus.inst_add + imm12_ext;
    if (bus.is_jalr) begin
      target = bus.rs1_val + imm12_ext;
    end else if (bus.is_jal) begin
      target = inst_q + imm20_ext;
    end else begin
      target = inst_q + imm12_ext;
    end
  end

  // State, index, link and error registers; reset overrides stall
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT;
      inst_q  <= '0;
      link_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      inst_q  <= inst_nxt;
      link_q  <= link_nxt;
      err_q   <= err_nxt;
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_nxt = state_q;
    inst_nxt  = inst_q;
    link_nxt  = link_q;
    err_nxt   = err_q;
    case (state_q)
      INIT: begin
        state_nxt = RUN;
        inst_nxt  = '0;
      end
      RUN: begin
        if (!bus.stall) begin
          if (redirect) begin
            if (bus.is_jalr || bus.is_jal) begin
              link_nxt = inst_q + STEP_W;
            end
            if (target <= LAST_W) begin
              inst_nxt  = target;
              state_nxt = FLUSH;
            end else begin
              err_nxt   = 1'b1;
              state_nxt = HALT;
            end
          end else if (inst_q < LAST_W) begin
            inst_nxt = inst_q + STEP_W;
          end else begin
            state_nxt = HALT;
          end
        end
      end
      FLUSH: begin
        if (!bus.stall) begin
          state_nxt = RUN;
        end
      end
      HALT: begin
        state_nxt = HALT;
      end
      default: begin
        state_nxt = INIT;
      end
    endcase
  end

  // Status outputs decoded from the registered state
  always_comb begin
    bus.inst_add = inst_q;
    bus.link_add = link_q;
    bus.err      = err_q;
    bus.valid    = (state_q == RUN);
    bus.halted   = (state_q == HALT);
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a vector table for the main redirect
// behaviour plus hand-written sequences for the multi-cycle cases.
module tb_pc_sequencer;

  logic clk;
  logic reset;

  pc_sequencer_if bus ();

  pc_sequencer #(.LAST_ADDR(26), .STEP(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        br;
    logic        jal;
    logic        jalr;
    logic [11:0] imm12;
    logic [19:0] imm20;
    logic [31:0] rs1;
    logic [31:0] e_inst;
    logic [31:0] e_link;
    logic        e_valid;
    logic        e_halted;
    logic        e_err;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];

  int checks;
  int errors;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name, act, act, exp, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] inst, input logic [31:0] link,
                           input logic v, input logic h, input logic e);
    check({tag, " inst_add"}, bus.inst_add, inst);
    check({tag, " link_add"}, bus.link_add, link);
    check({tag, " valid"},    {31'd0, bus.valid},  {31'd0, v});
    check({tag, " halted"},   {31'd0, bus.halted}, {31'd0, h});
    check({tag, " err"},      {31'd0, bus.err},    {31'd0, e});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.stall        = 1'b0;
    bus.branch_taken = 1'b0;
    bus.is_jal       = 1'b0;
    bus.is_jalr      = 1'b0;
    bus.imm12        = 12'd0;
    bus.imm20        = 20'd0;
    bus.rs1_val      = 32'd0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  function automatic vec_t mk(input logic rst, input logic stall, input logic br,
                              input logic jal, input logic jalr, input logic [11:0] i12,
                              input logic [19:0] i20, input logic [31:0] rs1,
                              input logic [31:0] ei, input logic [31:0] el,
                              input logic ev, input logic eh, input logic ee);
    vec_t v;
    v.rst = rst; v.stall = stall; v.br = br; v.jal = jal; v.jalr = jalr;
    v.imm12 = i12; v.imm20 = i20; v.rs1 = rs1;
    v.e_inst = ei; v.e_link = el; v.e_valid = ev; v.e_halted = eh; v.e_err = ee;
    return v;
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    clear_inputs();

    //            rst st br jl jr imm12    imm20   rs1    inst link v h e
    vecs[0]  = mk(1, 0, 0, 0, 0, 12'd0,   20'd0,  32'd0,  0,  0, 0, 0, 0);
    vecs[1]  = mk(1, 1, 1, 0, 0, 12'd5,   20'd0,  32'd0,  0,  0, 0, 0, 0);
    vecs[2]  = mk(0, 1, 0, 0, 0, 12'd0,   20'd0,  32'd0,  0,  0, 1, 0, 0);
    vecs[3]  = mk(0, 0, 0, 0, 0, 12'd0,   20'd0,  32'd0,  1,  0, 1, 0, 0);
    vecs[4]  = mk(0, 0, 0, 1, 0, 12'd0,   20'd12, 32'd0, 13,  2, 0, 0, 0);
    vecs[5]  = mk(0, 0, 0, 0, 0, 12'd0,   20'd0,  32'd0, 13,  2, 1, 0, 0);
    vecs[6]  = mk(0, 0, 0, 1, 0, 12'd0,   20'd5,  32'd0, 18, 14, 0, 0, 0);
    vecs[7]  = mk(0, 0, 0, 1, 0, 12'd0,   20'd100,32'd0, 18, 14, 1, 0, 0);
    vecs[8]  = mk(0, 0, 1, 0, 0, 12'hFF8, 20'd0,  32'd0, 10, 14, 0, 0, 0);
    vecs[9]  = mk(0, 0, 0, 0, 0, 12'd0,   20'd0,  32'd0, 10, 14, 1, 0, 0);
    vecs[10] = mk(0, 0, 1, 0, 0, 12'hFFC, 20'd0,  32'd0,  6, 14, 0, 0, 0);
    vecs[11] = mk(0, 0, 0, 0, 0, 12'd0,   20'd0,  32'd0,  6, 14, 1, 0, 0);
    vecs[12] = mk(0, 0, 1, 0, 0, 12'd4,   20'd0,  32'd0, 10, 14, 0, 0, 0);
    vecs[13] = mk(0, 0, 0, 0, 0, 12'd0,   20'd0,  32'd0, 10, 14, 1, 0, 0);
    vecs[14] = mk(0, 0, 1, 1, 1, 12'd1,   20'd5,  32'd3,  4, 11, 0, 0, 0);
    vecs[15] = mk(0, 0, 0, 0, 0, 12'd0,   20'd0,  32'd0,  4, 11, 1, 0, 0);
    vecs[16] = mk(0, 0, 1, 1, 0, 12'd10,  20'd2,  32'd0,  6,  5, 0, 0, 0);
    vecs[17] = mk(0, 0, 0, 0, 0, 12'd0,   20'd0,  32'd0,  6,  5, 1, 0, 0);
    vecs[18] = mk(0, 1, 0, 0, 0, 12'd0,   20'd0,  32'd0,  6,  5, 1, 0, 0);
    vecs[19] = mk(0, 1, 0, 0, 1, 12'd1,   20'd0,  32'd25, 6,  5, 1, 0, 0);
    vecs[20] = mk(0, 0, 0, 0, 1, 12'd1,   20'd0,  32'd25,26,  7, 0, 0, 0);
    vecs[21] = mk(0, 0, 0, 0, 0, 12'd0,   20'd0,  32'd0, 26,  7, 1, 0, 0);
    vecs[22] = mk(0, 0, 0, 0, 0, 12'd0,   20'd0,  32'd0, 26,  7, 0, 1, 0);
    vecs[23] = mk(0, 0, 1, 0, 0, 12'hFFC, 20'd0,  32'd0, 26,  7, 0, 1, 0);
    vecs[24] = mk(1, 0, 0, 0, 0, 12'd0,   20'd0,  32'd0,  0,  0, 0, 0, 0);

    @(negedge clk);
    for (int i = 0; i < NV; i++) begin
      reset            = vecs[i].rst;
      bus.stall        = vecs[i].stall;
      bus.branch_taken = vecs[i].br;
      bus.is_jal       = vecs[i].jal;
      bus.is_jalr      = vecs[i].jalr;
      bus.imm12        = vecs[i].imm12;
      bus.imm20        = vecs[i].imm20;
      bus.rs1_val      = vecs[i].rs1;
      tick();
      check_all($sformatf("vec%0d", i), vecs[i].e_inst, vecs[i].e_link,
                vecs[i].e_valid, vecs[i].e_halted, vecs[i].e_err);
    end

    // Full sequential run from reset to halt
    do_reset();
    check_all("run init", 0, 0, 0, 0, 0);
    for (int i = 0; i <= 26; i++) begin
      tick();
      check($sformatf("run inst%0d", i), bus.inst_add, i);
      check($sformatf("run valid%0d", i), {31'd0, bus.valid}, 32'd1);
    end
    tick();
    check_all("run end", 26, 0, 0, 1, 0);

    // Stall in RUN and during FLUSH
    do_reset();
    for (int i = 0; i <= 5; i++) tick();
    check("stall pre", bus.inst_add, 5);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all($sformatf("stall run%0d", i), 5, 0, 1, 0, 0);
    end
    bus.stall = 1'b0;
    tick();
    check_all("stall resume", 6, 0, 1, 0, 0);
    bus.branch_taken = 1'b1;
    bus.imm12 = 12'd3;
    tick();
    check_all("stall br", 9, 0, 0, 0, 0);
    bus.branch_taken = 1'b0;
    bus.is_jal = 1'b1;
    bus.imm20 = 20'd1;
    bus.stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_all($sformatf("stall flush%0d", i), 9, 0, 0, 0, 0);
    end
    bus.stall = 1'b0;
    tick();
    check_all("flush exit", 9, 0, 1, 0, 0);
    bus.is_jal = 1'b0;
    tick();
    check_all("after flush", 10, 0, 1, 0, 0);

    // Out-of-range JALR, then ignored branch, then reset clears err
    do_reset();
    for (int i = 0; i <= 2; i++) tick();
    bus.is_jalr = 1'b1;
    bus.rs1_val = 32'd40;
    bus.imm12 = 12'd0;
    tick();
    check_all("err jalr", 2, 3, 0, 1, 1);
    bus.is_jalr = 1'b0;
    bus.branch_taken = 1'b1;
    bus.imm12 = 12'd1;
    tick();
    check_all("err hold", 2, 3, 0, 1, 1);
    do_reset();
    check_all("err reset", 0, 0, 0, 0, 0);

    // Negative wrap target at index 0
    tick();
    bus.branch_taken = 1'b1;
    bus.imm12 = 12'hFFF;
    tick();
    check_all("wrap err", 0, 0, 0, 1, 1);

    // Reset while in FLUSH with stall asserted
    do_reset();
    tick();
    tick();
    bus.is_jal = 1'b1;
    bus.imm20 = 20'd3;
    tick();
    check_all("mid jal", 4, 2, 0, 0, 0);
    bus.is_jal = 1'b0;
    bus.stall = 1'b1;
    reset = 1'b1;
    tick();
    check_all("mid reset", 0, 0, 0, 0, 0);
    reset = 1'b0;
    tick();
    check_all("post init", 0, 0, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
